// File: rtl/cpu_pipe_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the FSM state encoding and the default field widths.
package cpu_pipe_pkg;

    localparam int REG_W = 5;
    localparam int PC_W  = 5;

    localparam logic [2:0] JUMP_NONE = 3'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REFILL   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count holds once it reaches all ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, MEM-stage redirects
// and load-use hazards, plus saturating stall/flush counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal issue; load-use, redirect and memory-wait detection
// ST_MEM_WAIT | pipeline frozen until dmem_ack or the wait timer expires
// ST_REFILL   | IF/ID held as bubble while imem refetches after a redirect
module pipeline_hazard_ctrl #(
    parameter int PC_W          = cpu_pipe_pkg::PC_W,
    parameter int REG_W         = cpu_pipe_pkg::REG_W,
    parameter int REFILL_CYCLES = 1,
    parameter int MEM_TIMEOUT   = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_to_reg,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic [2:0]       mem_jump_type,
    input  logic             mem_branch_taken,
    input  logic [PC_W-1:0]  mem_target_pc,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_sel,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             dmem_timeout
);

    import cpu_pipe_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam int REF_W  = (REFILL_CYCLES > 0) ? $clog2(REFILL_CYCLES + 1) : 1;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [REF_W-1:0]  refill_cnt, refill_nxt;
    logic              ret_refill, ret_nxt;
    logic              timeout_set;
    logic              redirect_evt;
    logic              load_use;
    logic              redirect;
    logic              mem_stall;

    assign redirect_pc = mem_target_pc;

    assign load_use  = ex_mem_to_reg && (ex_write_reg != '0) &&
                       ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
    assign redirect  = (mem_jump_type != JUMP_NONE) && mem_branch_taken;
    assign mem_stall = dmem_req && !dmem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            refill_cnt   <= '0;
            ret_refill   <= 1'b0;
            dmem_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            refill_cnt <= refill_nxt;
            ret_refill <= ret_nxt;
            if (timeout_set) begin
                dmem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pc_sel       = 1'b0;
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        refill_nxt   = refill_cnt;
        ret_nxt      = ret_refill;
        timeout_set  = 1'b0;
        redirect_evt = 1'b0;

        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state)
                ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_nxt = ret_refill ? ST_REFILL : ST_RUN;
                        wait_nxt  = '0;
                    end else if (wait_cnt == '0) begin
                        // Wait timer expired: let MEM advance with whatever it has.
                        timeout_set = 1'b1;
                        state_nxt   = ret_refill ? ST_REFILL : ST_RUN;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                        wait_nxt = wait_cnt - WAIT_W'(1);
                    end
                end
                default: begin
                    if (mem_stall) begin
                        // This cycle already counts as the first wait cycle.
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                        ret_nxt   = (state == ST_REFILL);
                        wait_nxt  = WAIT_W'(MEM_TIMEOUT - 2);
                        state_nxt = ST_MEM_WAIT;
                    end else if (redirect) begin
                        pc_sel       = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        exmem_flush  = 1'b1;
                        redirect_evt = 1'b1;
                        if (REFILL_CYCLES > 0) begin
                            state_nxt  = ST_REFILL;
                            refill_nxt = REF_W'(REFILL_CYCLES);
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end else begin
                        if (state == ST_REFILL) begin
                            ifid_flush = 1'b1;
                            if (refill_cnt <= REF_W'(1)) begin
                                state_nxt  = ST_RUN;
                                refill_nxt = '0;
                            end else begin
                                refill_nxt = refill_cnt - REF_W'(1);
                            end
                        end else begin
                            state_nxt = ST_RUN;
                        end
                        if (load_use) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (!rst && !pc_en),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (redirect_evt),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: expected control vectors and counter
// values are queued per driven cycle and compared when the outputs settle.
module tb_pipeline_hazard_ctrl;

    localparam int PC_W  = 5;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, pc_sel}
    localparam logic [8:0] CTL_DEF = 9'b11111_000_0;
    localparam logic [8:0] CTL_RST = 9'b11111_111_0;
    localparam logic [8:0] CTL_LU  = 9'b00111_010_0;
    localparam logic [8:0] CTL_RED = 9'b11111_111_1;
    localparam logic [8:0] CTL_REF = 9'b11111_100_0;
    localparam logic [8:0] CTL_FRZ = 9'b00000_000_0;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_to_reg;
    logic [REG_W-1:0] ex_write_reg;
    logic [2:0]       mem_jump_type;
    logic             mem_branch_taken;
    logic [PC_W-1:0]  mem_target_pc;
    logic             dmem_req;
    logic             dmem_ack;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic             pc_sel;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             dmem_timeout;

    typedef struct {
        string            tag;
        logic [8:0]       ctl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic             m_tmo   = 1'b0;

    pipeline_hazard_ctrl #(
        .PC_W          (PC_W),
        .REG_W         (REG_W),
        .REFILL_CYCLES (1),
        .MEM_TIMEOUT   (4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_write_reg     (ex_write_reg),
        .mem_jump_type    (mem_jump_type),
        .mem_branch_taken (mem_branch_taken),
        .mem_target_pc    (mem_target_pc),
        .dmem_req         (dmem_req),
        .dmem_ack         (dmem_ack),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exmem_en         (exmem_en),
        .memwb_en         (memwb_en),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .pc_sel           (pc_sel),
        .redirect_pc      (redirect_pc),
        .stall_count      (stall_count),
        .flush_count      (flush_count),
        .dmem_timeout     (dmem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs            = '0;
        id_rt            = '0;
        id_uses_rt       = 1'b0;
        ex_mem_to_reg    = 1'b0;
        ex_write_reg     = '0;
        mem_jump_type    = 3'd0;
        mem_branch_taken = 1'b0;
        mem_target_pc    = '0;
        dmem_req         = 1'b0;
        dmem_ack         = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic run_cycle(input string tag, input logic [8:0] ctl, input logic forced);
        exp_t e;
        e.tag   = tag;
        e.ctl   = ctl;
        e.stall = m_stall;
        e.flush = m_flush;
        e.tmo   = m_tmo;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        check_eq({e.tag, ".ctl"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                       ifid_flush, idex_flush, exmem_flush, pc_sel}), 32'(e.ctl));
        check_eq({e.tag, ".stall_count"}, 32'(stall_count), 32'(e.stall));
        check_eq({e.tag, ".flush_count"}, 32'(flush_count), 32'(e.flush));
        check_eq({e.tag, ".dmem_timeout"}, 32'(dmem_timeout), 32'(e.tmo));
        if (rst) begin
            m_stall = '0;
            m_flush = '0;
            m_tmo   = 1'b0;
        end else begin
            if (!ctl[8] && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if (ctl[0] && (m_flush != '1)) m_flush = m_flush + 1'b1;
            if (forced) m_tmo = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        run_cycle("reset", CTL_RST, 1'b0);
        rst = 1'b0;
        run_cycle("idle", CTL_DEF, 1'b0);

        ex_mem_to_reg = 1'b1; ex_write_reg = 5'd5; id_rs = 5'd5;
        run_cycle("load_use_rs", CTL_LU, 1'b0);
        clear_inputs();
        run_cycle("after_load_use", CTL_DEF, 1'b0);

        ex_mem_to_reg = 1'b1; ex_write_reg = 5'd0; id_rs = 5'd0;
        run_cycle("r0_guard", CTL_DEF, 1'b0);
        ex_write_reg = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        run_cycle("rt_unused", CTL_DEF, 1'b0);
        id_uses_rt = 1'b1;
        run_cycle("load_use_rt", CTL_LU, 1'b0);
        clear_inputs();

        mem_jump_type = 3'd1; mem_branch_taken = 1'b0; mem_target_pc = 5'd17;
        run_cycle("not_taken", CTL_DEF, 1'b0);
        mem_jump_type = 3'd0; mem_branch_taken = 1'b1;
        run_cycle("taken_no_jump", CTL_DEF, 1'b0);

        mem_jump_type = 3'd1; mem_branch_taken = 1'b1; mem_target_pc = 5'd17;
        ex_mem_to_reg = 1'b1; ex_write_reg = 5'd5; id_rs = 5'd5;
        #1 check_eq("redirect_pc", 32'(redirect_pc), 32'd17);
        run_cycle("redirect", CTL_RED, 1'b0);
        clear_inputs();
        run_cycle("refill", CTL_REF, 1'b0);
        run_cycle("post_refill", CTL_DEF, 1'b0);

        dmem_req = 1'b1; dmem_ack = 1'b1;
        run_cycle("req_ack_same", CTL_DEF, 1'b0);
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle($sformatf("mem_wait%0d", i), CTL_FRZ, 1'b0);
        dmem_ack = 1'b1;
        run_cycle("mem_ack", CTL_DEF, 1'b0);
        clear_inputs();
        run_cycle("after_ack", CTL_DEF, 1'b0);

        mem_jump_type = 3'd2; mem_branch_taken = 1'b1; mem_target_pc = 5'd9;
        run_cycle("redirect2", CTL_RED, 1'b0);
        clear_inputs();
        dmem_req = 1'b1;
        run_cycle("refill_wait", CTL_FRZ, 1'b0);
        dmem_ack = 1'b1;
        run_cycle("refill_ack", CTL_DEF, 1'b0);
        clear_inputs();
        run_cycle("refill_resume", CTL_REF, 1'b0);
        run_cycle("refill_done", CTL_DEF, 1'b0);

        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle($sformatf("tmo_wait%0d", i), CTL_FRZ, 1'b0);
        run_cycle("tmo_forced", CTL_DEF, 1'b1);
        clear_inputs();
        run_cycle("tmo_sticky", CTL_DEF, 1'b0);
        run_cycle("tmo_sticky2", CTL_DEF, 1'b0);

        dmem_req = 1'b1;
        run_cycle("rst_wait1", CTL_FRZ, 1'b0);
        rst = 1'b1;
        run_cycle("rst_mid_wait", CTL_RST, 1'b0);
        rst = 1'b0;
        clear_inputs();
        run_cycle("after_reset", CTL_DEF, 1'b0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
